// File: rtl/vote_display_ctrl.sv
// LED/mode controller for the voting machine: acknowledge flash, latched result selection, saturating count display.
// Optional: define VOTE_DISPLAY_WINNER_EN to show the leading candidate one-hot when no selection is latched.
module vote_display_ctrl #(
    parameter int NUM_CAND   = 4,
    parameter int VOTE_W     = 8,
    parameter int LED_W      = 8,
    parameter int ACK_CYCLES = 100000000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mode,
    input  logic                          valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0]    cand_votes,
    input  logic [NUM_CAND-1:0]           cand_button,
    output logic [LED_W-1:0]              leds,
    output logic                          ack_busy,
    output logic                          sel_valid,
    output logic [$clog2(NUM_CAND)-1:0]   sel_idx
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int CNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {
        VOTE_IDLE = 2'd0,
        VOTE_ACK  = 2'd1,
        RESULT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               ack_busy_q, ack_busy_d;
    logic               sel_valid_q, sel_valid_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;

    logic [VOTE_W-1:0]  votes [NUM_CAND];
    logic [VOTE_W-1:0]  sel_count;
    logic [LED_W-1:0]   sel_disp;
    logic [LED_W-1:0]   idle_disp;
    logic               press_any;
    logic [IDX_W-1:0]   press_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAND; gi++) begin : g_unpack
            assign votes[gi] = cand_votes[gi*VOTE_W +: VOTE_W];
        end
    endgenerate

    assign sel_count = votes[sel_idx_q];

    // Counts wider than the LED bar pin to all-ones rather than wrapping.
    generate
        if (VOTE_W > LED_W) begin : g_sat
            assign sel_disp = (|sel_count[VOTE_W-1:LED_W]) ? {LED_W{1'b1}} : sel_count[LED_W-1:0];
        end else begin : g_ext
            assign sel_disp = LED_W'(sel_count);
        end
    endgenerate

    // Scanning downward leaves the lowest pressed index as the winner.
    always_comb begin
        press_any = |cand_button;
        press_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_button[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOTE_DISPLAY_WINNER_EN
    logic [VOTE_W-1:0] best_cnt;
    logic [IDX_W-1:0]  best_idx;

    // Strict greater-than keeps the earlier candidate on ties.
    always_comb begin
        best_cnt  = votes[0];
        best_idx  = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (votes[i] > best_cnt) begin
                best_cnt = votes[i];
                best_idx = IDX_W'(i);
            end
        end
        idle_disp = '0;
        if ((best_cnt != '0) && (int'(best_idx) < LED_W)) begin
            idle_disp = LED_W'(1) << best_idx;
        end
    end
`else
    assign idle_disp = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_valid_d = sel_valid_q;
        sel_idx_d   = sel_idx_q;
        leds_d      = '0;
        ack_busy_d  = (state_q == VOTE_ACK);
        case (state_q)
            VOTE_IDLE: begin
                if (mode) begin
                    state_d = RESULT;
                end else if (valid_vote_casted) begin
                    state_d = VOTE_ACK;
                    cnt_d   = ACK_LOAD;
                end
            end
            VOTE_ACK: begin
                leds_d = '1;
                if (mode) begin
                    state_d = RESULT;
                    cnt_d   = '0;
                end else if (valid_vote_casted) begin
                    cnt_d = ACK_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = VOTE_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESULT: begin
                if (!mode) begin
                    state_d     = VOTE_IDLE;
                    sel_valid_d = 1'b0;
                end else begin
                    leds_d = sel_valid_q ? sel_disp : idle_disp;
                    if (press_any) begin
                        sel_valid_d = 1'b1;
                        sel_idx_d   = press_idx;
                    end
                end
            end
            default: begin
                state_d = VOTE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= VOTE_IDLE;
            cnt_q       <= '0;
            leds_q      <= '0;
            ack_busy_q  <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            leds_q      <= leds_d;
            ack_busy_q  <= ack_busy_d;
            sel_valid_q <= sel_valid_d;
            sel_idx_q   <= sel_idx_d;
        end
    end

    assign leds      = leds_q;
    assign ack_busy  = ack_busy_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Scoreboard bench for vote_display_ctrl: a 4x8/8 instance and a 2x10/8 instance for saturation.
module tb_vote_display_ctrl;

    logic        clock;
    logic        reset;
    logic        mode;
    logic        vote;
    logic [31:0] cand_votes;
    logic [3:0]  cand_button;
    logic [7:0]  leds;
    logic        ack_busy;
    logic        sel_valid;
    logic [1:0]  sel_idx;

    logic        mode_w;
    logic        vote_w;
    logic [19:0] cand_votes_w;
    logic [1:0]  btn_w;
    logic [7:0]  leds_w;
    logic        busy_w;
    logic        sv_w;
    logic [0:0]  idx_w;

    int cyc;
    int total;
    int bad;

    typedef struct {
        int          at;
        string       name;
        bit          wide;
        logic [7:0]  leds;
        logic        busy;
        logic        sv;
        logic [1:0]  idx;
    } exp_t;

    exp_t sb[$];

`ifdef VOTE_DISPLAY_WINNER_EN
    localparam logic [7:0] WIN_A = 8'h08;
    localparam logic [7:0] WIN_B = 8'h02;
`else
    localparam logic [7:0] WIN_A = 8'h00;
    localparam logic [7:0] WIN_B = 8'h00;
`endif

    vote_display_ctrl #(.NUM_CAND(4), .VOTE_W(8), .LED_W(8), .ACK_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .mode(mode), .valid_vote_casted(vote),
        .cand_votes(cand_votes), .cand_button(cand_button),
        .leds(leds), .ack_busy(ack_busy), .sel_valid(sel_valid), .sel_idx(sel_idx)
    );

    vote_display_ctrl #(.NUM_CAND(2), .VOTE_W(10), .LED_W(8), .ACK_CYCLES(4)) dut_w (
        .clock(clock), .reset(reset), .mode(mode_w), .valid_vote_casted(vote_w),
        .cand_votes(cand_votes_w), .cand_button(btn_w),
        .leds(leds_w), .ack_busy(busy_w), .sel_valid(sv_w), .sel_idx(idx_w)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops every expectation due at this cycle and compares away from the edge.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.at < cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.at, cyc);
            end else if (e.wide) begin
                if (leds_w !== e.leds) begin
                    bad++;
                    $display("FAIL %s: cycle %0d wide leds got %h want %h", e.name, cyc, leds_w, e.leds);
                end
            end else if (leds !== e.leds || ack_busy !== e.busy || sel_valid !== e.sv || sel_idx !== e.idx) begin
                bad++;
                $display("FAIL %s: cycle %0d got leds=%h busy=%b sv=%b idx=%0d want leds=%h busy=%b sv=%b idx=%0d",
                         e.name, cyc, leds, ack_busy, sel_valid, sel_idx, e.leds, e.busy, e.sv, e.idx);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_at(input int d, input string n, input bit w, input logic [7:0] l,
                             input logic b, input logic s, input logic [1:0] ix);
        exp_t e;
        e.at = cyc + d; e.name = n; e.wide = w; e.leds = l; e.busy = b; e.sv = s; e.idx = ix;
        sb.push_back(e);
    endtask

    initial begin
        cyc = 0; total = 0; bad = 0;
        reset = 1'b1; mode = 1'b1; vote = 1'b0; cand_button = 4'b1111; cand_votes = '0;
        mode_w = 1'b0; vote_w = 1'b0; btn_w = '0; cand_votes_w = '0;

        // Reset held with mode and buttons active
        expect_at(1, "reset1", 0, 8'h00, 0, 0, 2'd0);
        expect_at(2, "reset2", 0, 8'h00, 0, 0, 2'd0);
        step(); step();
        reset = 1'b0; mode = 1'b0; cand_button = '0;
        expect_at(1, "idle", 0, 8'h00, 0, 0, 2'd0);
        step();

        // Single vote: flash for edges t+1..t+4
        vote = 1'b1;
        expect_at(1, "vote_t", 0, 8'h00, 0, 0, 2'd0);
        for (int d = 2; d <= 5; d++) expect_at(d, "vote_flash", 0, 8'hFF, 1, 0, 2'd0);
        expect_at(6, "vote_end", 0, 8'h00, 0, 0, 2'd0);
        step(); vote = 1'b0;
        repeat (5) step();

        // Retrigger at t+2: flash through t+6
        vote = 1'b1;
        expect_at(1, "retrig_t", 0, 8'h00, 0, 0, 2'd0);
        for (int d = 2; d <= 7; d++) expect_at(d, "retrig_flash", 0, 8'hFF, 1, 0, 2'd0);
        expect_at(8, "retrig_end", 0, 8'h00, 0, 0, 2'd0);
        step(); vote = 1'b0;
        step(); vote = 1'b1;
        step(); vote = 1'b0;
        repeat (5) step();

        // Result mode with counts {9,7,3,5}
        cand_votes = {8'd9, 8'd7, 8'd3, 8'd5};
        mode = 1'b1;
        expect_at(1, "enter_res", 0, 8'h00, 0, 0, 2'd0);
        step();
        cand_button = 4'b0110;
        expect_at(1, "press", 0, WIN_A, 0, 1, 2'd1);
        step(); cand_button = '0;
        expect_at(1, "sel1", 0, 8'h03, 0, 1, 2'd1);
        step();
        cand_votes[15:8] = 8'd4;
        expect_at(1, "live", 0, 8'h04, 0, 1, 2'd1);
        step();
        vote = 1'b1;
        expect_at(1, "hold_vote_ign", 0, 8'h04, 0, 1, 2'd1);
        step(); vote = 1'b0;
        cand_button = 4'b1100;
        expect_at(1, "repress", 0, 8'h04, 0, 1, 2'd2);
        step(); cand_button = '0;
        expect_at(1, "sel2", 0, 8'h07, 0, 1, 2'd2);
        step();

        // Leave result with a simultaneous vote (ignored), then a press in voting mode
        mode = 1'b0; vote = 1'b1;
        expect_at(1, "leave", 0, 8'h00, 0, 0, 2'd2);
        step(); vote = 1'b0; cand_button = 4'b0001;
        expect_at(1, "left", 0, 8'h00, 0, 0, 2'd2);
        step(); cand_button = '0;
        expect_at(1, "press_ign", 0, 8'h00, 0, 0, 2'd2);
        step();

        // Result mode without selection: counts {4,9,9,2}
        cand_votes = {8'd4, 8'd9, 8'd9, 8'd2};
        mode = 1'b1;
        expect_at(1, "nosel_enter", 0, 8'h00, 0, 0, 2'd2);
        expect_at(2, "nosel_win", 0, WIN_B, 0, 0, 2'd2);
        step(); step();
        cand_votes = '0;
        expect_at(1, "all_zero", 0, 8'h00, 0, 0, 2'd2);
        step();
        mode = 1'b0;
        expect_at(1, "back_vote", 0, 8'h00, 0, 0, 2'd2);
        step();

        // Vote flash cut short by mode=1
        vote = 1'b1;
        expect_at(1, "ack_start", 0, 8'h00, 0, 0, 2'd2);
        step(); vote = 1'b0; mode = 1'b1;
        expect_at(1, "ack_to_res", 0, 8'hFF, 1, 0, 2'd2);
        step();
        expect_at(1, "res_after_ack", 0, 8'h00, 0, 0, 2'd2);
        step(); mode = 1'b0;
        expect_at(1, "res_exit", 0, 8'h00, 0, 0, 2'd2);
        step();

        // Wide counts on the 10-bit instance
        mode_w = 1'b1; cand_votes_w = {10'h0A5, 10'h1FF};
        step();
        btn_w = 2'b01;
        step(); btn_w = '0;
        expect_at(1, "wide_sat", 1, 8'hFF, 0, 0, 2'd0);
        step();
        cand_votes_w[9:0] = 10'h0A5;
        expect_at(1, "wide_low", 1, 8'hA5, 0, 0, 2'd0);
        step();
        cand_votes_w[19:10] = 10'h200; btn_w = 2'b10;
        expect_at(1, "wide_repress", 1, 8'hA5, 0, 0, 2'd0);
        step(); btn_w = '0;
        expect_at(1, "wide_sat_hi", 1, 8'hFF, 0, 0, 2'd0);
        step();

        step(); step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
